// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states, geometry and
// the idle row drive pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_e;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    localparam logic [KEY_ROWS-1:0] ROW_IDLE = 4'b1110;

    // Index of the lowest-numbered low bit; several keys in one row resolve to
    // the lowest column.
    function automatic logic [1:0] lowest_low(input logic [KEY_COLS-1:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running slot divider: one-cycle tick every SCAN_DIV clocks.
// Shared with the display driver's digit multiplexer.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row strobing, debounced press and
// release, key code with a one-cycle valid strobe and a held level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [KEY_ROWS-1:0]   row,
    input  logic [KEY_COLS-1:0]   col,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS);

    logic                  tick;
    logic [KEY_COLS-1:0]   col_p0, col_s;
    kp_state_e             state, state_n;
    logic [1:0]            row_idx, row_idx_n;
    logic [1:0]            cand_row, cand_row_n;
    logic [1:0]            cand_col, cand_col_n;
    logic [DW-1:0]         deb, deb_n, deb_inc;
    logic [KEY_CODE_W-1:0] key_code_n;
    logic                  key_valid_n, key_held_n;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Column synchroniser: col is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_p0 <= '1;
            col_s  <= '1;
        end else begin
            col_p0 <= col;
            col_s  <= col_p0;
        end
    end

    assign row     = ~(4'b0001 << row_idx);
    assign deb_inc = deb + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            deb       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            row_idx   <= row_idx_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            deb       <= deb_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        cand_row_n  = cand_row;
        cand_col_n  = cand_col;
        deb_n       = deb;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (col_s == 4'b1111) begin
                        row_idx_n = row_idx + 1'b1;
                    end else begin
                        cand_row_n = row_idx;
                        cand_col_n = lowest_low(col_s);
                        deb_n      = '0;
                        state_n    = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (col_s[cand_col]) begin
                        state_n = SCAN;
                    end else begin
                        deb_n = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            key_code_n  = {cand_row, cand_col};
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            state_n     = PRESSED;
                        end
                    end
                end
                PRESSED: begin
                    // Only the accepted column matters: no rollover while held
                    if (col_s[cand_col]) begin
                        deb_n   = '0;
                        state_n = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (!col_s[cand_col]) begin
                        state_n = PRESSED;
                    end else begin
                        deb_n = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            key_held_n = 1'b0;
                            row_idx_n  = cand_row + 1'b1;
                            state_n    = SCAN;
                        end
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

endmodule
